// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the trigger generator family.
//   trig_state_t : burst FSM state encoding (values fixed for register-map
//                  compatibility with existing debug readback).
//   trig_is_busy : true for the states in which a burst is in progress.
// -----------------------------------------------------------------------------
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } trig_state_t;

    function automatic logic trig_is_busy(input trig_state_t st);
        return (st == ST_DELAY) || (st == ST_ACTIVE) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// -----------------------------------------------------------------------------
// trig_edge_det
// Two-flop rising-edge detector. o_rise is high for one cycle after the first
// clock edge that samples i_d high following a sample of i_d low.
//   i_clk  : clock
//   i_rst  : synchronous active-low reset (history cleared to 00)
//   i_d    : level input to watch
//   o_rise : rising-edge strobe (decoded from the history register)
// -----------------------------------------------------------------------------
module trig_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    // shift[0] is the newest sample, shift[1] the previous one
    logic [1:0] shift;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            shift <= '0;
        end else begin
            shift <= {shift[0], i_d};
        end
    end

    assign o_rise = (shift == 2'b01);

endmodule

// File: rtl/trig_burst_gen.sv
// -----------------------------------------------------------------------------
// trig_burst_gen
// Programmable trigger burst generator. A rising edge on i_en starts a burst:
// optional start delay, then i_count pulses of programmable width and period
// (i_count = 0 runs until abort). Configuration is frozen for the burst.
//   i_clk       : clock
//   i_rst       : synchronous active-low reset
//   i_en        : start request, rising-edge sensitive
//   i_abort     : level, terminates any burst without o_done
//   i_out_level : active level of o_trig
//   i_delay     : cycles from start to first pulse
//   i_width     : active cycles per pulse (0 treated as 1)
//   i_period    : cycles from one pulse start to the next
//   i_count     : pulses per burst, 0 = continuous
//   o_trig      : registered trigger output
//   o_busy      : burst in progress (same latency as o_trig)
//   o_done      : one-cycle strobe on normal completion
// -----------------------------------------------------------------------------
module trig_burst_gen
    import trig_pkg::*;
#(
    parameter int TW = 16,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_abort,
    input  logic          i_out_level,
    input  logic [TW-1:0] i_delay,
    input  logic [TW-1:0] i_width,
    input  logic [TW-1:0] i_period,
    input  logic [CW-1:0] i_count,
    output logic          o_trig,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    trig_state_t   state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] width_q, gap_q;
    logic [CW-1:0] count_q;
    logic          pol_q;
    logic          done_first_q;

    logic          start;
    logic          latch_cfg;
    logic          more_pulses;
    logic [TW-1:0] width_in, gap_in;
    logic [CW:0]   pcnt_inc;
    logic [CW-1:0] pcnt_sat;

    trig_edge_det u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_en),
        .o_rise (start)
    );

    // Effective timing, derived from the raw inputs at the latch edge
    assign width_in = (i_width == '0) ? T_ONE : i_width;
    assign gap_in   = (i_period > width_in) ? (i_period - width_in) : T_ONE;

    // Extra bit so pulse_cnt+1 cannot wrap when compared against the count
    assign pcnt_inc    = {1'b0, pcnt_q} + {{CW{1'b0}}, 1'b1};
    assign more_pulses = (count_q == '0) || (pcnt_inc < {1'b0, count_q});
    // Saturates so continuous mode never lands on a terminating value
    assign pcnt_sat    = (pcnt_q == '1) ? pcnt_q : (pcnt_q + C_ONE);

    // Phase counter is loaded with (duration-1) on entry and counts down to 0
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        latch_cfg = 1'b0;
        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        latch_cfg = 1'b1;
                        pcnt_d    = '0;
                        if (i_delay != '0) begin
                            state_d = ST_DELAY;
                            cnt_d   = i_delay - T_ONE;
                        end else begin
                            state_d = ST_ACTIVE;
                            cnt_d   = width_in - T_ONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = width_q - T_ONE;
                    end else begin
                        cnt_d = cnt_q - T_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == '0) begin
                        pcnt_d = pcnt_sat;
                        if (more_pulses) begin
                            state_d = ST_GAP;
                            cnt_d   = gap_q - T_ONE;
                        end else begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - T_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = width_q - T_ONE;
                    end else begin
                        cnt_d = cnt_q - T_ONE;
                    end
                end
                ST_DONE: begin
                    // Wait for i_en low so a held-high enable cannot retrigger
                    if (!i_en) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            width_q <= '0;
            gap_q   <= '0;
            count_q <= '0;
            pol_q   <= 1'b1;
        end else begin
            if (latch_cfg) begin
                width_q <= width_in;
                gap_q   <= gap_in;
                count_q <= i_count;
            end
            // Tracking in IDLE also captures the level at the start edge
            if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
                pol_q <= i_out_level;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_trig       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            o_trig       <= (state_q == ST_ACTIVE) ? pol_q : ~pol_q;
            o_busy       <= trig_is_busy(state_q);
            done_first_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
            o_done       <= done_first_q;
        end
    end

endmodule

// File: tb/tb_trig_burst_gen.sv
module tb_trig_burst_gen;

    localparam int TW = 16;
    localparam int CW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_en = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_out_level = 1'b1;
    logic [TW-1:0] i_delay = '0;
    logic [TW-1:0] i_width = '0;
    logic [TW-1:0] i_period = '0;
    logic [CW-1:0] i_count = '0;
    logic          o_trig;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;
    int e = 0;  // number of rising edges seen so far

    always #5 i_clk = ~i_clk;

    trig_burst_gen #(.TW(TW), .CW(CW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_abort     (i_abort),
        .i_out_level (i_out_level),
        .i_delay     (i_delay),
        .i_width     (i_width),
        .i_period    (i_period),
        .i_count     (i_count),
        .o_trig      (o_trig),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        int   d, w, p, n;
        logic lvl;
        int   a_rel, hold, rep;
        int   first, done, rises;
    } vec_t;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge i_clk);
        e++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, $signed(act), $signed(exp), e);
        end
    endtask

    // Expected {o_trig, o_busy, o_done} after edge t for a burst whose first
    // i_en=1 sample is edge k, with optional abort sampled at edge a.
    function automatic logic [2:0] model(input int t, input int k, input int d, input int w,
                                         input int g, input int n, input logic lvl, input int a);
        int p, rel, last_end;
        logic act, busy, done;
        p = w + g;
        rel = t - (k + 2 + d);
        last_end = (n - 1) * p + w;
        if (t < k + 2 || (a >= 0 && t >= a + 1)) return {~lvl, 2'b00};
        act  = (rel >= 0) && ((rel % p) < w) && (n == 0 || (rel / p) < n);
        busy = (n == 0) || (rel < last_end);
        done = (n != 0) && (rel == last_end);
        return {act ? lvl : ~lvl, busy, done};
    endfunction

    task automatic run_burst(input int d, input int w, input int p, input int n, input logic lvl,
                             input int a_rel, input int hold, input int rep,
                             output int first_on, output int done_at, output int rises);
        int k, a, we, ge, lim;
        logic [2:0] exp_v, got;
        logic prev;
        we = (w == 0) ? 1 : w;
        ge = (p > we) ? p - we : 1;
        i_en = 1'b0;
        i_abort = 1'b0;
        i_out_level = lvl;
        i_delay = TW'(d);
        i_width = TW'(w);
        i_period = TW'(p);
        i_count = CW'(n);
        repeat (3) tick();
        k = e + 1;
        a = (a_rel < 0) ? -1 : k + a_rel;
        lim = (n == 0) ? a + 4 : k + 2 + d + n * (we + ge) + 4;
        if (a >= 0 && a + 4 > lim) lim = a + 4;
        first_on = -1;
        done_at = -1;
        rises = 0;
        prev = ~lvl;
        for (int t = k; t <= lim; t++) begin
            i_en = ((t - k) < hold) || (rep > 0 && t == k + rep);
            i_abort = (t == a);
            if (t == k + 2) begin
                // Configuration is latched by now; scrambling must not matter
                i_delay = TW'($urandom);
                i_width = TW'($urandom);
                i_period = TW'($urandom);
                i_count = CW'($urandom);
            end
            tick();
            got = {o_trig, o_busy, o_done};
            exp_v = model(t, k, d, we, ge, n, lvl, a);
            check($sformatf("burst_t%0d{trig,busy,done}", t - k), {29'd0, got}, {29'd0, exp_v});
            if (o_trig === lvl) begin
                if (first_on < 0) first_on = t - k;
                if (prev !== lvl) rises++;
            end
            if (o_done === 1'b1 && done_at < 0) done_at = t - k;
            prev = o_trig;
        end
        i_en = 1'b0;
        i_abort = 1'b0;
        repeat (2) tick();
    endtask

    vec_t tbl[10];

    initial begin
        int fo, da, rs, ok;
        int d, w, p, n, we, ge, span, a_rel;
        logic lvl;

        //          d  w   p  n  lvl   a_rel hold rep first done rises
        tbl[0] = '{0, 4,  0, 1, 1'b1,  -1,   1,  0,  2,    6,   1};
        tbl[1] = '{5, 2,  6, 3, 1'b1,  -1,   2,  0,  7,   21,   3};
        tbl[2] = '{0, 0,  1, 2, 1'b1,  -1,   1,  0,  2,    5,   2};
        tbl[3] = '{3, 2,  3, 2, 1'b0,  -1,   1,  0,  5,   10,   2};
        tbl[4] = '{0, 2,  8, 3, 1'b1,  -1,   1,  5,  2,   20,   3};
        tbl[5] = '{1, 1, 10, 1, 1'b1,  -1,  60,  0,  3,    4,   1};
        tbl[6] = '{2, 3,  2, 2, 1'b0,  -1,   1,  0,  4,   11,   2};
        tbl[7] = '{0, 3,  8, 0, 1'b1, 163,   1,  0,  2,   -1,  21};
        tbl[8] = '{0, 1,  2, 0, 1'b1, 602,   1,  0,  2,   -1, 301};
        tbl[9] = '{0, 4,  0, 1, 1'b1,   1,   1,  0, -1,   -1,   0};

        // Reset state
        i_rst = 1'b0;
        repeat (3) tick();
        check("reset_trig", {31'd0, o_trig}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);
        i_rst = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_burst(tbl[i].d, tbl[i].w, tbl[i].p, tbl[i].n, tbl[i].lvl,
                      tbl[i].a_rel, tbl[i].hold, tbl[i].rep, fo, da, rs);
            check($sformatf("v%0d_first_on", i), fo, tbl[i].first);
            check($sformatf("v%0d_done_at", i), da, tbl[i].done);
            check($sformatf("v%0d_pulses", i), rs, tbl[i].rises);
        end

        // Reset mid-ACTIVE with low polarity: output must go to 0, not idle level
        i_out_level = 1'b0;
        i_delay = '0;
        i_width = TW'(10);
        i_period = '0;
        i_count = CW'(1);
        repeat (3) tick();
        i_en = 1'b1;
        ok = 0;
        for (int c = 0; c < 10 && ok == 0; c++) begin
            tick();
            if (o_trig === 1'b0) ok = 1;
        end
        check("rst_wait_active", ok, 1);
        i_rst = 1'b0;
        i_en = 1'b0;
        tick();
        check("rst_mid_trig", {31'd0, o_trig}, 32'd0);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b1;
        repeat (3) tick();
        check("rst_after_idle_low_pol", {31'd0, o_trig}, 32'd1);
        check("rst_after_busy", {31'd0, o_busy}, 32'd0);

        // Randomised bursts against the reference model
        for (int r = 0; r < 25; r++) begin
            d = $urandom_range(0, 6);
            w = $urandom_range(0, 5);
            p = $urandom_range(0, 12);
            n = $urandom_range(0, 4);
            lvl = 1'($urandom_range(0, 1));
            we = (w == 0) ? 1 : w;
            ge = (p > we) ? p - we : 1;
            span = 2 + d + ((n == 0) ? 4 : n) * (we + ge) + 2;
            a_rel = (n == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, span)) : -1;
            run_burst(d, w, p, n, lvl, a_rel, $urandom_range(1, 30), 0, fo, da, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_burst_gen.md
Name: trig_burst_gen

Overview:
- Parametrised successor to the single-pulse trigger generator.
- A rising edge on i_en starts a programmable burst: an optional start delay, then a set number of pulses, each with programmable width and period.
- Adds runtime polarity control, abort, busy/done status and a continuous mode.
- Sits between the control register block and the external trigger pin / downstream acquisition logic.

Parameters:
- TW, 16, width of delay/width/period fields (cycles).
- CW, 8, width of pulse-count field.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-low reset.
- i_en  in  1  start request, rising-edge sensitive.
- i_abort  in  1  level; forces burst termination.
- i_out_level  in  1  active level of o_trig (1 = active-high pulses).
- i_delay  in  TW  cycles from start to first pulse.
- i_width  in  TW  active cycles per pulse.
- i_period  in  TW  cycles from pulse start to next pulse start.
- i_count  in  CW  pulses per burst; 0 = continuous until abort.
- o_trig  out  1  trigger output, registered.
- o_busy  out  1  high while the burst is in progress.
- o_done  out  1  one-cycle pulse when the burst completes normally.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-low; it is sampled only on i_clk rising edges.
- Reset values: o_trig=0, o_busy=0, o_done=0, state=IDLE, all counters 0, en shift reg=00, polarity buffer=1.
- Edge detect: 2-bit shift register of i_en. start = (shift==01).
  - Edge k is the first edge that samples i_en=1.
  - start is valid during cycle k..k+1.
- Config latch: at the edge that consumes start, latch i_delay, i_width, i_period, i_count and i_out_level. These values are frozen until the FSM returns to IDLE.
  - In IDLE and DONE, the polarity buffer tracks i_out_level every cycle.
- Width rules: width_eff = max(i_width,1). gap_eff = period − width_eff if period > width_eff, else 1.
  - A pulse is never shorter than 1 cycle.
  - Adjacent pulses always have at least 1 idle cycle between them.
- FSM states and transitions:
  - IDLE: on start → DELAY if delay > 0, else ACTIVE.
  - DELAY: counts delay cycles, then → ACTIVE.
  - ACTIVE: counts width_eff cycles, then → GAP if pulses remain, else → DONE.
  - GAP: counts gap_eff cycles, then → ACTIVE.
  - DONE: stays until i_en is sampled 0, then → IDLE. This prevents retrigger from a held-high i_en.
- Pulse counter: increments on each ACTIVE exit.
  - Pulses remain while pulse_cnt+1 < count, or always when count==0.
  - In continuous mode the counter saturates at all-ones; it never wraps into a terminating value.
- Output:
  - o_trig = active level when the registered state is ACTIVE, else the inverse of the active level. This gives one cycle of latency from the state.
  - First active cycle of o_trig is after edge k+2+D. Each pulse is exactly width_eff cycles.
- o_busy: 1 in DELAY/ACTIVE/GAP, registered with the same latency as o_trig.
- o_done: 1 for exactly one cycle, aligned with the o_trig cycle after the last active cycle.
- start while busy: ignored, no restart.
- i_abort:
  - In any state, the next edge goes to IDLE, clears counters, and drives o_trig to idle level on the following edge.
  - No o_done is pulsed.
  - If abort and start occur in the same cycle, abort wins; the start is dropped.
- Reset mid-burst: same as the reset values above. Output goes to 0 regardless of the latched polarity.

Decomposition:
- Shared package trig_pkg holds the state encoding localparams:
  - ST_IDLE=3'd0
  - ST_DELAY=3'd1
  - ST_ACTIVE=3'd2
  - ST_GAP=3'd3
  - ST_DONE=3'd4
- Sub-module trig_edge_det: 2-flop rising-edge detector with synchronous active-low reset. Reused by other trigger blocks.
- Counters and the FSM stay in trig_burst_gen.

Test Plan:
- Single pulse: delay=0, width=4, period=0, count=1, level=1. i_en rises at edge 10 → o_trig=1 after edges 12..15, then 0. o_done=1 for one cycle after edge 16.
- Burst with delay: delay=5, width=2, period=6, count=3. o_trig high after edges k+7, k+13, k+19, each for 2 cycles. o_busy falls with o_done.
- Edge cases:
  - width=0, period=1, count=2 → two 1-cycle pulses separated by exactly 1 idle cycle.
  - Low polarity: level=0 → idle o_trig=1, pulses go to 0.
- Continuous plus abort: count=0, width=3, period=8. Run 20 pulses, assert i_abort mid-ACTIVE → o_trig to idle 2 edges later. No o_done; o_busy=0.
- Retrigger and reset:
  - Hold i_en high after done → no second burst until i_en drops and rises again.
  - Pulse i_en during GAP → ignored.
  - Assert i_rst low mid-ACTIVE → o_trig=0, o_busy=0 after the next edge.
